// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt pending front end.
package irq_pkg;
    localparam int NREQ   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/prio_enc8_v.sv
// 8-to-3 priority encoder: highest set bit wins, o = 0 when nothing is set.
module prio_enc8_v (
    input  logic [7:0] d,
    output logic [2:0] o,
    output logic       v
);
    always_comb begin
        o = '0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) o = 3'(i);
        end
    end

    assign v = |d;
endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending-request capture, mask and valid/ack grant of the highest eligible index.
//   state | meaning
//   IDLE  | valid=0, grant the highest eligible pending bit when one exists
//   GRANT | valid=1, code frozen until ack clears pending[code]
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   mask,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [NREQ-1:0]   pending,
    output logic              overrun
);
    state_t              state;
    logic [NREQ-1:0]     req_q;
    logic [NREQ-1:0]     set;
    logic [NREQ-1:0]     clr;
    logic [NREQ-1:0]     eligible;
    logic [CODE_W-1:0]   grant_idx;
    logic                grant_v;

    assign set      = EDGE ? (req & ~req_q) : req;
    assign clr      = (state == GRANT && ack) ? (NREQ'(1) << code) : '0;
    assign eligible = pending & ~mask;

    prio_enc8_v u_enc (
        .d (eligible),
        .o (grant_idx),
        .v (grant_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            overrun <= 1'b0;
            code    <= '0;
            valid   <= 1'b0;
            state   <= IDLE;
        end else begin
            req_q   <= req;
            // set is OR'ed last so a same-edge set survives the ack clear
            pending <= (pending & ~clr) | set;
            overrun <= |(set & pending & ~clr);
            case (state)
                IDLE: begin
                    if (grant_v) begin
                        code  <= grant_idx;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
